// File: rtl/wb_dma_arbiter.sv
// wb_dma_arbiter: shares the processor-module Wishbone bus between the
// 1801VM1 CPU (default owner) and up to NREQ DMA masters. DMA masters get
// the bus in round-robin order. A tenure is limited to MAXCYC acknowledged
// transfers, after which the CPU keeps the bus for CPU_MIN cycles.
module wb_dma_arbiter #(
    parameter int NREQ    = 2,
    parameter int MAXCYC  = 16,
    parameter int CPU_MIN = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,

    input  logic                 cpu_stb_i,
    input  logic [15:0]          cpu_adr_i,
    input  logic [15:0]          cpu_dat_i,
    input  logic                 cpu_we_i,
    input  logic [1:0]           cpu_sel_i,
    output logic                 cpu_gnt_o,

    input  logic [NREQ-1:0]      dma_req_i,
    output logic [NREQ-1:0]      dma_gnt_o,
    input  logic [NREQ-1:0]      dma_stb_i,
    input  logic [16*NREQ-1:0]   dma_adr_i,
    input  logic [16*NREQ-1:0]   dma_dat_i,
    input  logic [NREQ-1:0]      dma_we_i,
    input  logic [2*NREQ-1:0]    dma_sel_i,

    input  logic                 bus_ack_i,
    output logic [15:0]          bus_adr_o,
    output logic [15:0]          bus_dat_o,
    output logic                 bus_we_o,
    output logic [1:0]           bus_sel_o,
    output logic                 bus_stb_o,
    output logic                 bus_cyc_o,
    output logic [2:0]           owner_o
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SLOT_W = 16;

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } state_t;

    state_t              state_q;
    logic                cpu_gnt_q;
    logic [NREQ-1:0]     dma_gnt_q;
    logic [2:0]          owner_q;
    // Round-robin pointer; it also names the current DMA owner during a tenure.
    logic [IDX_W-1:0]    ptr_q;
    logic [7:0]          burst_q;
    logic [SLOT_W-1:0]   slot_q;

    logic                pick_vld_d;
    logic [IDX_W-1:0]    pick_idx_d;
    logic [IDX_W-1:0]    cand;
    logic [7:0]          burst_d;
    logic [SLOT_W-1:0]   slot_d;
    logic                ack_hit;
    logic                cur_stb;
    logic                cur_req;
    logic                limit_hit;

    // Round-robin search: the first requester after the pointer wins.
    // Walking offsets from far to near lets the nearest one overwrite.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = ptr_q;
        cand       = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % NREQ);
            if (dma_req_i[cand]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand;
            end
        end
    end

    // Burst, CPU-slot and release bookkeeping for the current owner.
    always_comb begin
        ack_hit   = bus_stb_o & bus_ack_i;
        cur_stb   = dma_stb_i[ptr_q];
        cur_req   = dma_req_i[ptr_q];
        limit_hit = (MAXCYC != 0) && (int'(burst_q) >= MAXCYC);

        burst_d = burst_q;
        if (ack_hit && (burst_q != 8'hFF)) begin
            burst_d = burst_q + 8'd1;
        end

        // The slot expires on the same edge that can hand the bus over,
        // so a CPU_MIN load gives the CPU exactly CPU_MIN owned cycles.
        slot_d = slot_q;
        if (slot_q != '0) begin
            slot_d = slot_q - SLOT_W'(1);
        end
    end

    // Ownership FSM with registered grants and owner code.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= CPU_OWN;
            cpu_gnt_q <= 1'b1;
            dma_gnt_q <= '0;
            owner_q   <= 3'd0;
            ptr_q     <= IDX_W'(NREQ - 1);
            burst_q   <= 8'd0;
            slot_q    <= '0;
        end else begin
            case (state_q)
                CPU_OWN: begin
                    slot_q <= slot_d;
                    // Never cut an open CPU cycle; wait for its strobe to fall.
                    if (pick_vld_d && (slot_d == '0) && !cpu_stb_i) begin
                        state_q   <= DMA_OWN;
                        cpu_gnt_q <= 1'b0;
                        dma_gnt_q <= NREQ'(1) << pick_idx_d;
                        owner_q   <= 3'(pick_idx_d) + 3'd1;
                        ptr_q     <= pick_idx_d;
                        burst_q   <= 8'd0;
                    end
                end
                DMA_OWN: begin
                    burst_q <= burst_d;
                    // Only release between transfers; other requests wait
                    // for the CPU_OWN pass so tenures never chain directly.
                    if (!cur_stb && (!cur_req || limit_hit)) begin
                        state_q   <= CPU_OWN;
                        cpu_gnt_q <= 1'b1;
                        dma_gnt_q <= '0;
                        owner_q   <= 3'd0;
                        slot_q    <= limit_hit ? SLOT_W'(CPU_MIN) : '0;
                    end
                end
                default: begin
                    state_q   <= CPU_OWN;
                    cpu_gnt_q <= 1'b1;
                    dma_gnt_q <= '0;
                    owner_q   <= 3'd0;
                end
            endcase
        end
    end

    // Bus mux driven from the registered owner; non-owners never reach the bus.
    always_comb begin
        bus_adr_o = '0;
        bus_dat_o = '0;
        bus_we_o  = 1'b0;
        bus_sel_o = '0;
        bus_stb_o = 1'b0;
        if (owner_q == 3'd0) begin
            if (cpu_gnt_q) begin
                bus_adr_o = cpu_adr_i;
                bus_dat_o = cpu_dat_i;
                bus_we_o  = cpu_we_i;
                bus_sel_o = cpu_sel_i;
                bus_stb_o = cpu_stb_i;
            end
        end else begin
            bus_adr_o = dma_adr_i[16*int'(ptr_q) +: 16];
            bus_dat_o = dma_dat_i[16*int'(ptr_q) +: 16];
            bus_we_o  = dma_we_i[ptr_q];
            bus_sel_o = dma_sel_i[2*int'(ptr_q) +: 2];
            bus_stb_o = dma_stb_i[ptr_q];
        end
    end

    assign bus_cyc_o = bus_stb_o;
    assign cpu_gnt_o = cpu_gnt_q;
    assign dma_gnt_o = dma_gnt_q;
    assign owner_o   = owner_q;

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Testbench for wb_dma_arbiter (NREQ=2, MAXCYC=16, CPU_MIN=8).
// Stimulus queues the expected grant/bus state per cycle; a monitor on the
// falling edge pops and compares whatever is due for the current cycle.
module tb_wb_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_stb;
    logic [15:0] cpu_adr;
    logic [15:0] cpu_dat;
    logic        cpu_we;
    logic [1:0]  cpu_sel;
    logic        cpu_gnt;
    logic [1:0]  dma_req;
    logic [1:0]  dma_gnt;
    logic [1:0]  dma_stb;
    logic [15:0] adr0, adr1;
    logic [1:0]  dma_we;
    logic [3:0]  dma_sel;
    logic        bus_ack;
    logic [15:0] bus_adr;
    logic [15:0] bus_dat;
    logic        bus_we;
    logic [1:0]  bus_sel;
    logic        bus_stb;
    logic        bus_cyc;
    logic [2:0]  owner;

    wb_dma_arbiter #(.NREQ(2), .MAXCYC(16), .CPU_MIN(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cpu_stb_i (cpu_stb),
        .cpu_adr_i (cpu_adr),
        .cpu_dat_i (cpu_dat),
        .cpu_we_i  (cpu_we),
        .cpu_sel_i (cpu_sel),
        .cpu_gnt_o (cpu_gnt),
        .dma_req_i (dma_req),
        .dma_gnt_o (dma_gnt),
        .dma_stb_i (dma_stb),
        .dma_adr_i ({adr1, adr0}),
        .dma_dat_i ({~adr1, ~adr0}),
        .dma_we_i  (dma_we),
        .dma_sel_i (dma_sel),
        .bus_ack_i (bus_ack),
        .bus_adr_o (bus_adr),
        .bus_dat_o (bus_dat),
        .bus_we_o  (bus_we),
        .bus_sel_o (bus_sel),
        .bus_stb_o (bus_stb),
        .bus_cyc_o (bus_cyc),
        .owner_o   (owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        cg;
        logic [1:0]  dg;
        logic [2:0]  ow;
        logic        cb;
        logic [15:0] adr;
        logic        stb;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic cg, input logic [1:0] dg, input logic [2:0] ow,
                        input logic cb, input logic [15:0] adr, input logic stb);
        exp_t e;
        e.cyc = cyc; e.cg = cg; e.dg = dg; e.ow = ow;
        e.cb = cb; e.adr = adr; e.stb = stb;
        q.push_back(e);
    endtask

    task automatic ex_cpu(input logic [15:0] adr, input logic stb);
        push(1'b1, 2'b00, 3'd0, 1'b1, adr, stb);
    endtask

    task automatic ex_dma(input int k);
        push(1'b0, (k == 0) ? 2'b01 : 2'b10, 3'(k + 1), 1'b0, 16'h0, 1'b0);
    endtask

    task automatic ex_dma_bus(input int k, input logic [15:0] adr, input logic stb);
        push(1'b0, (k == 0) ? 2'b01 : 2'b10, 3'(k + 1), 1'b1, adr, stb);
    endtask

    // Monitor: pop every expectation due this cycle and compare.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            n_chk++;
            if ((cpu_gnt && (dma_gnt != 2'b00)) || (bus_cyc !== bus_stb))
                $display("FAIL excl cyc=%0d got cpu_gnt=%b dma_gnt=%b cyc_o=%b stb_o=%b, need exclusive grants and cyc_o==stb_o",
                         cyc, cpu_gnt, dma_gnt, bus_cyc, bus_stb);
            else
                n_pass++;
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc)
                $display("FAIL missed cyc=%0d got expectation for cycle %0d, required cycle %0d", cyc, e.cyc, cyc);
            else if ({cpu_gnt, dma_gnt, owner} !== {e.cg, e.dg, e.ow})
                $display("FAIL grant cyc=%0d got cpu=%b dma=%b own=%0d, required cpu=%b dma=%b own=%0d",
                         cyc, cpu_gnt, dma_gnt, owner, e.cg, e.dg, e.ow);
            else
                n_pass++;
            if (e.cb) begin
                n_chk++;
                if ({bus_adr, bus_stb} !== {e.adr, e.stb})
                    $display("FAIL bus cyc=%0d got adr=%o stb=%b, required adr=%o stb=%b",
                             cyc, bus_adr, bus_stb, e.adr, e.stb);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no end of stimulus, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cpu_stb = 1'b0; cpu_adr = 16'o160000; cpu_dat = 16'h1234;
        cpu_we = 1'b0; cpu_sel = 2'b11; dma_req = 2'b00; dma_stb = 2'b00;
        adr0 = 16'h0; adr1 = 16'h0; dma_we = 2'b00; dma_sel = 4'hF; bus_ack = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state and idle
        for (int i = 0; i < 5; i++) begin
            ex_cpu(16'o160000, 1'b0);
            step();
        end

        // CPU cycle in progress holds off DMA0
        cpu_stb = 1'b1; dma_req = 2'b01;
        ex_cpu(16'o160000, 1'b1); step();
        ex_cpu(16'o160000, 1'b1); step();
        ex_cpu(16'o160000, 1'b1); step();
        cpu_stb = 1'b0;
        ex_cpu(16'o160000, 1'b0); step();
        ex_dma(0);

        // DMA0 four acked writes then drops its request
        for (int i = 0; i < 4; i++) begin
            dma_stb = 2'b01; dma_we = 2'b01; bus_ack = 1'b1;
            adr0 = 16'o001000 + 16'(2 * i);
            ex_dma_bus(0, 16'o001000 + 16'(2 * i), 1'b1);
            step();
        end
        dma_stb = 2'b00; bus_ack = 1'b0; dma_req = 2'b00;
        ex_dma_bus(0, 16'o001006, 1'b0); step();
        ex_cpu(16'o160000, 1'b0);

        // Continuous DMA0 request: revoked at MAXCYC, CPU holds 8 cycles
        dma_req = 2'b01;
        step();
        for (int i = 0; i < 16; i++) begin
            dma_stb = 2'b01; bus_ack = 1'b1;
            adr0 = 16'o002000 + 16'(2 * i);
            ex_dma_bus(0, 16'o002000 + 16'(2 * i), 1'b1);
            step();
        end
        dma_stb = 2'b00; bus_ack = 1'b0;
        ex_dma(0); step();
        for (int j = 0; j < 8; j++) begin
            ex_cpu(16'o160000, 1'b0);
            step();
        end
        ex_dma(0);
        dma_req = 2'b00;
        step();
        ex_cpu(16'o160000, 1'b0);

        // Fresh reset, then round-robin between both requesters
        rst = 1'b1; step(); rst = 1'b0;
        ex_cpu(16'o160000, 1'b0);
        dma_req = 2'b11; step();
        dma_stb = 2'b01; bus_ack = 1'b1; adr0 = 16'o003000;
        ex_dma_bus(0, 16'o003000, 1'b1); step();
        dma_stb = 2'b00; bus_ack = 1'b0; dma_req = 2'b10;
        ex_dma(0); step();
        ex_cpu(16'o160000, 1'b0);
        dma_req = 2'b11; step();
        dma_stb = 2'b10; bus_ack = 1'b1; adr1 = 16'o004000;
        ex_dma_bus(1, 16'o004000, 1'b1); step();
        dma_stb = 2'b00; bus_ack = 1'b0; dma_req = 2'b01;
        ex_dma(1); step();
        ex_cpu(16'o160000, 1'b0);
        dma_req = 2'b11; step();
        ex_dma(0);
        dma_req = 2'b10; step();
        ex_cpu(16'o160000, 1'b0); step();

        // Reset in the middle of an open DMA1 transfer
        dma_stb = 2'b10; adr1 = 16'o004100; cpu_stb = 1'b1;
        ex_dma_bus(1, 16'o004100, 1'b1); step();
        rst = 1'b1;
        ex_dma_bus(1, 16'o004100, 1'b1); step();
        rst = 1'b0;
        ex_cpu(16'o160000, 1'b1); step();
        cpu_stb = 1'b0; dma_req = 2'b00;
        ex_cpu(16'o160000, 1'b0); step();
        ex_cpu(16'o160000, 1'b0);
        dma_stb = 2'b00;
        step(); step();

        n_chk++;
        if (q.size() != 0)
            $display("FAIL drain got %0d pending expectations, required 0", q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
